// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI bus (mode 0, MSB first, two active-low slave selects)
// between two requesters using round-robin arbitration. Each requester
// raises req, receives a one-cycle gnt when its wdata has been captured,
// then a one-cycle done together with the received byte on rdata.
//
// Handshake: req is a level held by the requester until it sees done;
// gnt pulses for one cycle when wdata is captured; done pulses for one
// cycle when rdata is valid. If req is still high in the cycle after
// done, it is taken as a new request.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   req0/1              transfer request levels
//   wdata0/1 [7:0]      transmit bytes, captured on grant
//   gnt0/1              grant pulses
//   done0/1             completion pulses
//   rdata0/1 [7:0]      received bytes, updated with done
//   miso                serial data from slave
//   mosi, sclk          serial data to slave, SPI clock (idles low)
//   ss0, ss1            slave selects owned by requester 0 / 1
//   busy                high whenever the sequencer is not idle
module spi_bus_arbiter #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] wdata0,
    output logic       gnt0,
    output logic       done0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic [7:0] wdata1,
    output logic       gnt1,
    output logic       done1,
    output logic [7:0] rdata1,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       ss0,
    output logic       ss1,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);

    state_t        state;
    logic [CW-1:0] cnt;      // cycle counter within SETUP / HOLD / half-period
    logic [3:0]    half;     // SCLK half-period index within SHIFT
    logic [6:0]    tx;       // remaining transmit bits; bit 7 goes out at grant
    logic [7:0]    rx;
    logic          owner;    // requester that owns the current transfer
    logic          prio;     // requester that wins the next tie
    logic          winner;

    // Lone requester wins; on a tie the pointer decides.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) winner = prio;
        else if (req1)    winner = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            half   <= '0;
            tx     <= '0;
            rx     <= '0;
            owner  <= 1'b0;
            prio   <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            mosi   <= 1'b0;
            sclk   <= 1'b0;
            ss0    <= 1'b1;
            ss1    <= 1'b1;
            busy   <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= winner;
                        prio  <= ~winner;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                        ss0   <= winner;
                        ss1   <= ~winner;
                        tx    <= winner ? wdata1[6:0] : wdata0[6:0];
                        mosi  <= winner ? wdata1[7] : wdata0[7];
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        half  <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        half <= half + 4'd1;
                        if (!sclk) begin
                            // rising edge: sample slave data
                            rx <= {rx[6:0], miso};
                        end else if (half != 4'd15) begin
                            // falling edge: present next bit, except after the last
                            mosi <= tx[6];
                            tx   <= {tx[5:0], 1'b0};
                        end
                        if (half == 4'd15) state <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        ss0   <= 1'b1;
                        ss1   <= 1'b1;
                        mosi  <= 1'b0;
                        state <= DONE;
                        if (owner) begin
                            done1  <= 1'b1;
                            rdata1 <= rx;
                        end else begin
                            done0  <= 1'b1;
                            rdata0 <= rx;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: default-parameter instance with a loopback /
// mode-0 slave model, plus a CLK_DIV=1, CS_SETUP=1 loopback instance.
module tb_spi_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic       req0 = 0, req1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata0, rdata1;
    logic       miso, mosi, sclk, ss0, ss1, busy;

    // fast instance
    logic       b_req0 = 0;
    logic [7:0] b_wdata0 = 0;
    logic       b_gnt0, b_gnt1, b_done0, b_done1;
    logic [7:0] b_rdata0, b_rdata1;
    logic       b_mosi, b_sclk, b_ss0, b_ss1, b_busy;

    spi_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .miso(miso), .mosi(mosi), .sclk(sclk), .ss0(ss0), .ss1(ss1), .busy(busy)
    );

    spi_bus_arbiter #(.CLK_DIV(1), .CS_SETUP(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .wdata0(b_wdata0), .gnt0(b_gnt0), .done0(b_done0), .rdata0(b_rdata0),
        .req1(1'b0), .wdata1(8'h00), .gnt1(b_gnt1), .done1(b_done1), .rdata1(b_rdata1),
        .miso(b_mosi), .mosi(b_mosi), .sclk(b_sclk), .ss0(b_ss0), .ss1(b_ss1), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model (mode 0) ----------------
    logic       loop = 1'b1;
    logic [7:0] slv_load = 8'h00;
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_prev = 1'b0;
    assign miso = loop ? mosi : slv_tx[7];

    always @(negedge clk) begin
        if (ss0 && ss1) slv_tx <= slv_load;
        else if (slv_prev && !sclk) slv_tx <= {slv_tx[6:0], 1'b0};
        if (!slv_prev && sclk) slv_rx <= {slv_rx[6:0], mosi};
        slv_prev <= sclk;
    end

    // ---------------- scoreboard ----------------
    logic [0:0] gnt_q[$];     // expected grant port
    logic [8:0] exp_q[$];     // expected {port, rdata}
    logic [7:0] b_exp_q[$];   // expected rdata of the fast instance
    int gnt_cyc = 0;
    int b_gnt_cyc = 0;
    logic prev_idle = 1'b1;

    always @(negedge clk) begin
        logic [0:0] eg;
        logic [8:0] ed;
        logic [7:0] eb;
        cyc++;
        if (!rst) begin
            if (!ss0 && !ss1) begin
                checks++;
                errors++;
                $display("FAIL ss_exclusive: got ss0=%0b ss1=%0b required not both low", ss0, ss1);
            end
            if (gnt0 || gnt1) begin
                if (gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_gnt: got gnt0=%0b gnt1=%0b required none", gnt0, gnt1);
                end else begin
                    eg = gnt_q.pop_front();
                    chk("gnt_port", {30'd0, gnt0, gnt1}, eg[0] ? 32'd1 : 32'd2);
                end
                chk("idle_gap", {31'd0, prev_idle}, 32'd1);
                gnt_cyc = cyc;
            end
            if (done0 || done1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b required none", done0, done1);
                end else begin
                    ed = exp_q.pop_front();
                    chk("done_data", {22'd0, done0, done1, (done1 ? rdata1 : rdata0)},
                        {22'd0, ~ed[8], ed[8], ed[7:0]});
                    chk("done_latency", cyc - gnt_cyc, 32'd68);
                end
            end
            prev_idle = ss0 && ss1;

            if (b_gnt0) b_gnt_cyc = cyc;
            if (b_done0) begin
                if (b_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_done: got rdata %0h required none", b_rdata0);
                end else begin
                    eb = b_exp_q.pop_front();
                    chk("b_rdata", {24'd0, b_rdata0}, {24'd0, eb});
                    chk("b_latency", cyc - b_gnt_cyc, 32'd18);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 b_gnt0, 5 b_done0
    task automatic wait_event(input string name, input int sel, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0: seen = gnt0;
                1: seen = gnt1;
                2: seen = done0;
                3: seen = done1;
                4: seen = b_gnt0;
                default: seen = b_done0;
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_%s: got no event within %0d cycles required event", name, budget);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int rises, ss0_low, ss1_low, dones, changes, highs;
        bit seen;
        logic prev_s;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ss", {30'd0, ss0, ss1}, 32'd3);
        chk("rst_sclk_mosi_busy", {29'd0, sclk, mosi, busy}, 32'd0);
        chk("rst_pulses", {28'd0, gnt0, gnt1, done0, done1}, 32'd0);
        chk("rst_rdata", {16'd0, rdata0, rdata1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // slave returns 0x3C to requester 1 sending 0xC3
        loop = 1'b0;
        slv_load = 8'h3C;
        wdata1 = 8'hC3;
        gnt_q.push_back(1'b1);
        exp_q.push_back({1'b1, 8'h3C});
        req1 = 1'b1;
        wait_event("gnt1", 1, 20);
        wdata1 = 8'($urandom_range(0, 255));
        wait_event("done1", 3, 100);
        req1 = 1'b0;
        chk("slave_rx", {24'd0, slv_rx}, 32'hC3);
        chk("rdata0_untouched", {24'd0, rdata0}, 32'h00);

        // loopback 0xA5 on requester 0, with bus activity measured
        loop = 1'b1;
        wdata0 = 8'hA5;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 8'hA5});
        req0 = 1'b1;
        wait_event("gnt0", 0, 20);
        wdata0 = 8'h00;
        rises = 0; ss0_low = ss0 ? 0 : 1; ss1_low = 0; prev_s = sclk; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
            else begin
                if (!prev_s && sclk) rises++;
                prev_s = sclk;
                if (!ss0) ss0_low++;
                if (!ss1) ss1_low++;
            end
        end
        req0 = 1'b0;
        chk("loop_done_seen", {31'd0, seen}, 32'd1);
        chk("sclk_rises", rises, 32'd8);
        chk("ss0_low_cycles", ss0_low, 32'd68);
        chk("ss1_low_cycles", ss1_low, 32'd0);
        chk("rdata1_held", {24'd0, rdata1}, 32'h3C);

        // both requesting from reset: alternate 0,1,0,1
        pulse_reset();
        chk("rdata0_after_rst", {24'd0, rdata0}, 32'h00);
        wdata0 = 8'h11;
        wdata1 = 8'h22;
        for (int i = 0; i < 2; i++) begin
            gnt_q.push_back(1'b0);
            gnt_q.push_back(1'b1);
            exp_q.push_back({1'b0, 8'h11});
            exp_q.push_back({1'b1, 8'h22});
        end
        req0 = 1'b1;
        req1 = 1'b1;
        dones = 0;
        for (int i = 0; i < 400 && dones < 4; i++) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rr_done_count", dones, 32'd4);

        // req0 dropped 10 cycles after its grant
        wdata0 = 8'h5A;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 8'h5A});
        req0 = 1'b1;
        wait_event("gnt0_drop", 0, 20);
        repeat (10) @(negedge clk);
        req0 = 1'b0;
        wait_event("done0_drop", 2, 100);
        repeat (6) @(negedge clk);
        chk("drop_idle", {30'd0, busy, ss0}, 32'd1);

        // reset during SHIFT after the 3rd rising sclk edge
        wdata0 = 8'hFF;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 8'hFF});
        req0 = 1'b1;
        wait_event("gnt0_rst", 0, 20);
        rises = 0; prev_s = sclk;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            @(negedge clk);
            if (!prev_s && sclk) rises++;
            prev_s = sclk;
        end
        chk("rst_rises_reached", rises, 32'd3);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("abort_ss", {30'd0, ss0, ss1}, 32'd3);
        chk("abort_sclk_mosi_busy", {29'd0, sclk, mosi, busy}, 32'd0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_rdata0", {24'd0, rdata0}, 32'h00);
        repeat (80) @(negedge clk);

        // simultaneous request after reset goes to requester 0
        wdata0 = 8'h42;
        wdata1 = 8'h99;
        gnt_q.push_back(1'b0);
        exp_q.push_back({1'b0, 8'h42});
        req0 = 1'b1;
        req1 = 1'b1;
        wait_event("gnt0_tie", 0, 20);
        req1 = 1'b0;
        wait_event("done0_tie", 2, 100);
        req0 = 1'b0;
        repeat (4) @(negedge clk);

        // fast instance: CLK_DIV=1, CS_SETUP=1, loopback 0x81
        b_wdata0 = 8'h81;
        b_exp_q.push_back(8'h81);
        b_req0 = 1'b1;
        wait_event("b_gnt0", 4, 20);
        changes = 0; highs = 0; prev_s = b_sclk; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (b_done0) seen = 1;
            else begin
                if (b_sclk != prev_s) changes++;
                if (b_sclk) highs++;
                prev_s = b_sclk;
            end
        end
        b_req0 = 1'b0;
        chk("b_done_seen", {31'd0, seen}, 32'd1);
        chk("b_sclk_changes", changes, 32'd16);
        chk("b_sclk_high_cycles", highs, 32'd8);
        repeat (4) @(negedge clk);

        chk("queues_drained", gnt_q.size() + exp_q.size() + b_exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
